// File: rtl/instr_fetch_unit_if.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit_if
//
// Purpose : Bundles the bus-side signals of the instruction fetch unit:
//           the program-ROM address/data pair, the redirect request from
//           execute and the {PC, instruction} valid/ready channel to decode.
//
// Signals :
//   rom_pc      - fetch address presented to the synchronous ROM
//   rom_instr   - ROM data, word for the rom_pc sampled on the previous edge
//   redirect    - flush and restart fetch at redirect_pc
//   redirect_pc - restart address, bits [1:0] ignored
//   out_valid   - out_pc/out_instr hold a valid fetched pair
//   out_ready   - decode accepts the pair this cycle
//   out_instr   - fetched instruction
//   out_pc      - address of out_instr
//
// Modports:
//   master - the fetch unit
//   slave  - the environment (ROM, execute, decode)
// ----------------------------------------------------------------------------
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] rom_pc;
  logic [DATA_W-1:0] rom_instr;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_instr;
  logic [ADDR_W-1:0] out_pc;

  modport master (
    output rom_pc, out_valid, out_instr, out_pc,
    input  rom_instr, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  rom_pc, out_valid, out_instr, out_pc,
    output rom_instr, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//
// Purpose : Owns the program counter and drives the address side of a
//           synchronous program ROM with one-cycle registered read latency.
//           Returned words are buffered in a 2-entry queue and handed to
//           decode as {PC, instruction} pairs over valid/ready. Branch/jump
//           redirects from execute flush everything and restart fetch.
//
// Ports   :
//   i_clk  - rising-edge clock, shared with the ROM
//   i_rst  - synchronous, active-high reset
//   io_bus - instr_fetch_unit_if.master (ROM, redirect and decode channels)
//
// Options :
//   FETCH_BYPASS_EN - when defined, a word returning from the ROM while the
//                     queue is empty is forwarded to decode in the same cycle
//                     (1-cycle fetch-to-output latency). Undefined: every word
//                     goes through the queue and all outputs are registered.
// ----------------------------------------------------------------------------
module instr_fetch_unit #(
  parameter int              ADDR_W   = 8,
  parameter int              DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  instr_fetch_unit_if.master io_bus
);

  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_inflight_v;
  logic [ADDR_W-1:0] r_inflight_pc;
  // Shift-style queue: entry 0 is always the head, so it feeds the outputs
  // directly without a read-pointer mux.
  logic [ADDR_W-1:0] r_fifo_pc    [2];
  logic [DATA_W-1:0] r_fifo_instr [2];
  logic [1:0]        r_count;

  logic       w_capture;
  logic       w_bypass;
  logic       w_pop;
  logic       w_fifo_pop;
  logic       w_push;
  logic       w_wr_idx;
  logic [1:0] w_occupancy;
  logic       w_issue;

  // A returned word is only kept if no redirect is flushing it this cycle.
  assign w_capture = r_inflight_v && !io_bus.redirect;

`ifdef FETCH_BYPASS_EN
  assign w_bypass         = w_capture && (r_count == 2'd0);
  assign io_bus.out_valid = (r_count != 2'd0) || w_bypass;
  assign io_bus.out_instr = w_bypass ? io_bus.rom_instr : r_fifo_instr[0];
  assign io_bus.out_pc    = w_bypass ? r_inflight_pc    : r_fifo_pc[0];
`else
  assign w_bypass         = 1'b0;
  assign io_bus.out_valid = (r_count != 2'd0);
  assign io_bus.out_instr = r_fifo_instr[0];
  assign io_bus.out_pc    = r_fifo_pc[0];
`endif

  assign io_bus.rom_pc = r_fetch_pc;

  assign w_pop = io_bus.out_valid && io_bus.out_ready;
  // A bypassed word that decode takes immediately never touches the queue.
  assign w_fifo_pop = w_pop && !w_bypass;
  assign w_push     = w_capture && !(w_bypass && w_pop);

  // Slot for the pushed word, as seen after this cycle's pop has shifted.
  assign w_wr_idx = (r_count == 2'd2) || ((r_count == 2'd1) && !w_fifo_pop);

  // Words held or on their way after this cycle's pop; a new request is only
  // allowed when its word is guaranteed a free slot on return.
  assign w_occupancy = r_count + 2'(r_inflight_v) - 2'(w_pop);
  assign w_issue     = !i_rst && !io_bus.redirect && (w_occupancy < 2'd2);

  // NOTE: non-blocking assignments throughout so every register samples the
  // pre-edge values; the pop shift and the push below rely on that ordering.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fetch_pc    <= RESET_PC;
      r_inflight_v  <= 1'b0;
      r_inflight_pc <= '0;
      r_count       <= 2'd0;
      // NOTE: queue storage is reset because its head drives out_pc/out_instr
      // directly and those must read zero out of reset.
      for (int i = 0; i < 2; i++) begin
        r_fifo_pc[i]    <= '0;
        r_fifo_instr[i] <= '0;
      end
    end else if (io_bus.redirect) begin
      // Stale queue contents stay in place; out_valid is low while count is 0.
      r_fetch_pc   <= {io_bus.redirect_pc[ADDR_W-1:2], 2'b00};
      r_inflight_v <= 1'b0;
      r_count      <= 2'd0;
    end else begin
      r_inflight_v <= w_issue;
      if (w_issue) begin
        r_inflight_pc <= r_fetch_pc;
        r_fetch_pc    <= r_fetch_pc + ADDR_W'(4);
      end
      if (w_fifo_pop) begin
        r_fifo_pc[0]    <= r_fifo_pc[1];
        r_fifo_instr[0] <= r_fifo_instr[1];
      end
      // Placed after the shift so a push into slot 0 wins over it.
      if (w_push) begin
        r_fifo_pc[w_wr_idx]    <= r_inflight_pc;
        r_fifo_instr[w_wr_idx] <= io_bus.rom_instr;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_fifo_pop);
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Purpose : Self-checking bench for instr_fetch_unit together with a
//           behavioural synchronous program ROM. Delivered pairs are checked
//           against a queue of expected PCs refilled on every reset/redirect;
//           output timing around redirect is checked from a vector table.
//           Honors FETCH_BYPASS_EN for the expected latency.
// ----------------------------------------------------------------------------
module tb_instr_fetch_unit;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
`ifdef FETCH_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] pc  [4];
    logic [DATA_W-1:0] ins [4];
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  instr_fetch_unit_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  instr_fetch_unit #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .RESET_PC(8'h00)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .io_bus(bus)
  );

  // Program ROM: 64 words, one-cycle registered read.
  logic [DATA_W-1:0] rom [64];
  logic [DATA_W-1:0] rom_q;
  always @(posedge clk) rom_q <= rom[bus.rom_pc[7:2]];
  assign bus.rom_instr = rom_q;

  function automatic logic [DATA_W-1:0] filler(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  int errors = 0;
  int checks = 0;
  logic [ADDR_W-1:0] exp_q [$];

  logic              s_valid;
  logic [ADDR_W-1:0] s_pc;
  logic [ADDR_W-1:0] s_rom_pc;
  logic [DATA_W-1:0] s_instr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic sb_restart(input logic [ADDR_W-1:0] start);
    exp_q.delete();
    for (int i = 0; i < 32; i++) exp_q.push_back(start + 8'(4 * i));
  endtask

  // Inputs are already driven; settle, sample, score any handshake, advance.
  task automatic step();
    logic [ADDR_W-1:0] e;
    #1;
    s_valid  = bus.out_valid;
    s_pc     = bus.out_pc;
    s_instr  = bus.out_instr;
    s_rom_pc = bus.rom_pc;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected: got pc %h, no output expected", s_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_pc", 32'(s_pc), 32'(e));
        check("sb_instr", s_instr, rom[e[7:2]]);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vecs [4];
    logic [ADDR_W-1:0] aligned;

    for (int i = 0; i < 64; i++) rom[i] = filler(i);
    rom[0] = 32'h00450693;
    rom[1] = 32'h00100713;
    rom[2] = 32'h00b76463;
    rom[7] = 32'hffc62883;
    rom[8] = 32'h01185a63;

    vecs[0].target = 8'h1F;
    vecs[0].pc     = '{8'h1C, 8'h20, 8'h24, 8'h28};
    vecs[0].ins    = '{32'hffc62883, 32'h01185a63, filler(9), filler(10)};
    vecs[1].target = 8'h00;
    vecs[1].pc     = '{8'h00, 8'h04, 8'h08, 8'h0C};
    vecs[1].ins    = '{32'h00450693, 32'h00100713, 32'h00b76463, filler(3)};
    vecs[2].target = 8'h06;
    vecs[2].pc     = '{8'h04, 8'h08, 8'h0C, 8'h10};
    vecs[2].ins    = '{32'h00100713, 32'h00b76463, filler(3), filler(4)};
    vecs[3].target = 8'hF8;
    vecs[3].pc     = '{8'hF8, 8'hFC, 8'h00, 8'h04};
    vecs[3].ins    = '{filler(62), filler(63), 32'h00450693, 32'h00100713};

    // Reset state.
    rst             = 1'b1;
    bus.out_ready   = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 8'h00;
    repeat (3) step();
    check("rst_valid", 32'(s_valid), 32'd0);
    check("rst_rom_pc", 32'(s_rom_pc), 32'h00);
    check("rst_out_pc", 32'(s_pc), 32'h00);
    check("rst_out_instr", s_instr, 32'h0);

    // Reset release, decode always ready: 00, 04, 08 back to back.
    sb_restart(8'h00);
    rst = 1'b0;
    for (int k = 0; k <= LAT + 3; k++) begin
      step();
      check("rel_valid", 32'(s_valid), 32'(k >= LAT));
      if (k >= LAT && k < LAT + 3) begin
        check("rel_pc", 32'(s_pc), 32'(vecs[1].pc[k - LAT]));
        check("rel_instr", s_instr, vecs[1].ins[k - LAT]);
      end
    end

    // Backpressure from reset: queue fills, fetch stalls at 08.
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_restart(8'h00);
    bus.out_ready = 1'b0;
    repeat (10) step();
    check("bp_rom_pc", 32'(s_rom_pc), 32'h08);
    check("bp_valid", 32'(s_valid), 32'd1);
    check("bp_head_pc", 32'(s_pc), 32'h00);
    bus.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("bp_stream_valid", 32'(s_valid), 32'd1);
    end

    // Redirect while the queue is full (handshake coincides with redirect).
    for (int v = 0; v < 4; v++) begin
      bus.out_ready = 1'b0;
      repeat (4) step();
      aligned         = {vecs[v].target[7:2], 2'b00};
      bus.redirect    = 1'b1;
      bus.redirect_pc = vecs[v].target;
      bus.out_ready   = 1'b1;
      step();
      sb_restart(aligned);
      bus.redirect = 1'b0;
      for (int j = 1; j <= LAT + 4; j++) begin
        step();
        check("redir_valid", 32'(s_valid), 32'(j >= LAT + 1));
        if (j == 1) check("redir_rom_pc", 32'(s_rom_pc), 32'(aligned));
        if (j >= LAT + 1) begin
          check("redir_pc", 32'(s_pc), 32'(vecs[v].pc[j - LAT - 1]));
          check("redir_instr", s_instr, vecs[v].ins[j - LAT - 1]);
        end
      end
    end

    // Redirect while a word is in flight: that word must be dropped.
    bus.redirect    = 1'b1;
    bus.redirect_pc = 8'h40;
    step();
    sb_restart(8'h40);
    bus.redirect = 1'b0;
    for (int j = 1; j <= LAT + 2; j++) begin
      step();
      check("cap_valid", 32'(s_valid), 32'(j >= LAT + 1));
      if (j == LAT + 1) begin
        check("cap_pc", 32'(s_pc), 32'h40);
        check("cap_instr", s_instr, filler(16));
      end
    end

    // Reset mid-stream with the queue full.
    bus.out_ready = 1'b0;
    repeat (4) step();
    check("mr_full_valid", 32'(s_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb_restart(8'h00);
    bus.out_ready = 1'b1;
    for (int k = 0; k <= LAT + 2; k++) begin
      step();
      if (k == 0) check("mr_rom_pc", 32'(s_rom_pc), 32'h00);
      check("mr_valid", 32'(s_valid), 32'(k >= LAT));
      if (k == LAT) begin
        check("mr_pc", 32'(s_pc), 32'h00);
        check("mr_instr", s_instr, 32'h00450693);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch unit that owns the program counter and drives the address side of the synchronous program ROM. It issues word-aligned fetch addresses, tracks the ROM's one-cycle registered read latency, and buffers returned words in a 2-entry queue. It hands {PC, instruction} pairs to decode over a valid/ready handshake and accepts branch/jump redirects from execute.

## Interface
Parameters:
- ADDR_W, 8, fetch address width; matches ROM PC input.
- DATA_W, 32, instruction width.
- RESET_PC, 8'h00, first fetch address after reset.

Ports:
- Clock  in  1  rising-edge clock, shared with the ROM.
- Reset  in  1  synchronous, active-high reset.
- RomPC  out  ADDR_W  address to ROM PC input; equals the internal FetchPC register.
- RomInstr  in  DATA_W  ROM Instr output; holds the word for the RomPC sampled at the previous edge.
- Redirect  in  1  flush and restart fetch at RedirectPC.
- RedirectPC  in  ADDR_W  new fetch address; bits [1:0] ignored and treated as 0.
- OutValid  out  1  OutInstr/OutPC hold a valid fetched pair.
- OutReady  in  1  decode accepts the pair this cycle.
- OutInstr  out  DATA_W  fetched instruction.
- OutPC  out  ADDR_W  address of OutInstr.

## Operation
- State: FetchPC, InflightV plus InflightPC (the request issued last cycle), 2-entry FIFO of {PC, Instr}, and Count in the range 0..2.
- Pop: OutValid && OutReady.
- Issue condition: !Reset && !Redirect && (Count - Pop + InflightV) < 2.
- On issue: InflightV <= 1, InflightPC <= FetchPC, and FetchPC <= FetchPC + 4. The add is modulo 2^ADDR_W, so 8'hFC wraps to 8'h00.
- With no issue, FetchPC holds and InflightV <= 0. The ROM re-reads the same address, which is harmless.
- Capture: when InflightV && !Redirect, {InflightPC, RomInstr} is pushed into the FIFO. The issue rule guarantees this push never overflows.
- Simultaneous push and pop: Count is unchanged and FIFO order is preserved.
- Redirect has top priority over pop, push and issue:
  - FIFO is cleared, Count <= 0, InflightV <= 0.
  - FetchPC <= {RedirectPC[ADDR_W-1:2], 2'b00}.
  - No issue occurs that cycle.
  - A handshake that coincides with Redirect counts as completed toward decode; the unit drops its own copy.
- Reset, including mid-operation: FetchPC <= RESET_PC, Count <= 0, InflightV <= 0, FIFO storage cleared.
- Reset values: RomPC = RESET_PC, OutValid = 0, OutInstr = 0, OutPC = 0.
- The unit never decodes instruction contents. Unpopulated ROM addresses return whatever the ROM outputs, and that value is passed through unchanged.

## Timing
- Without the bypass option:
  - Address presented in cycle N is sampled by the ROM at the end of N.
  - The word is pushed at the end of N+1 and appears on OutValid/OutInstr in N+2.
  - Fetch-to-output latency is 2 cycles.
- Sustained throughput is 1 instruction per cycle while OutReady = 1.
- Backpressure: with OutReady = 0, at most 2 words are held (FIFO full) and FetchPC stalls. No word is lost or duplicated.
- After Redirect in cycle R:
  - RedirectPC is issued in R+1.
  - The first valid output appears in R+3, or R+2 with bypass.
  - OutValid = 0 during R+1 .. R+2, or during R+1 only with bypass.
- All outputs except the bypass path come from registers. There is no combinational path from Redirect or OutReady to any output.

## Configuration
- FETCH_BYPASS_EN defined:
  - When Count = 0 and a capture occurs, RomInstr/InflightPC drive OutInstr/OutPC combinationally and OutValid = 1 in the same cycle.
  - If also popped that cycle, nothing is pushed.
  - Latency is 1 cycle.
- FETCH_BYPASS_EN undefined: every word passes through the FIFO, latency is 2 cycles, and all outputs are registered.

## Test plan
The bench instantiates the program ROM together with this unit.
- Reset release with OutReady = 1 -> OutPC/OutInstr sequence 00/32'h00450693, 04/32'h00100713, 08/32'h00b76463, one per cycle. The first OutValid comes 2 cycles after reset deassertion (1 with FETCH_BYPASS_EN).
- OutReady = 0 for 10 cycles, then 1 -> Count saturates at 2, RomPC frozen at 8'h08 (after the 8'h00 and 8'h04 fetches). Output resumes with PC 00, 04, 08 and no gaps or duplicates.
- Redirect = 1 with RedirectPC = 8'h1F while the FIFO holds 2 entries -> FIFO flushed, then next outputs are PC 1C/32'hffc62883 followed by PC 20/32'h01185a63.
- Redirect and capture in the same cycle -> the in-flight word is discarded and never appears on OutInstr.
- Force FetchPC near 8'hFC via Redirect = 8'hF8 -> output PCs F8, FC, 00, 04 (wrap-around).
- Assert Reset mid-stream with the FIFO full -> the next cycle shows OutValid = 0 and RomPC = 8'h00, then the sequence restarts from PC 00.
